// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, RX FIFO depth
// and the FIFO pointer-width helper.
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // One extra MSB distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// RX FIFO storage: DEPTH x DATA_BITS register array.
// Synchronous write port, asynchronous read port, no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_RX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_BITS-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_BITS-1:0]     rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Write the addressed entry on the clock edge.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART receiver.
// Define UART_RX_FIFO_COUNT_EN to add the count port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_RX_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
`ifdef UART_RX_FIFO_COUNT_EN
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH):0]     count
`else
  input  logic                       ovf_clr
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 drop;
  logic [DATA_BITS-1:0] ram_q;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);
  assign drop   = wr_en && full && !rd_en;

  assign rd_data = empty ? '0 : ram_q;

  uart_fifo_ram #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(ram_q)
  );

  // Advance pointers on accepted writes and reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky drop flag; a new drop beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

`ifdef UART_RX_FIFO_COUNT_EN
  // Registered occupancy tracking accepted traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else
      count <= count + PW'(wr_acc) - PW'(rd_acc);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table,
// queue scoreboard and hand-written corner sequences.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DW = UART_DATA_BITS;
  localparam int DP = UART_RX_FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          ovf_clr;
`ifdef UART_RX_FIFO_COUNT_EN
  logic [$clog2(DP):0] count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf;
  logic [DW-1:0] last_pop;

  typedef struct {
    bit            we;
    logic [DW-1:0] wd;
    bit            re;
    bit            clr;
    bit            e_empty;
    bit            e_full;
    bit            e_ovf;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .overflow(overflow),
`ifdef UART_RX_FIFO_COUNT_EN
    .ovf_clr (ovf_clr),
    .count   (count)
`else
    .ovf_clr (ovf_clr)
`endif
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic check_state();
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DP));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_data", 32'(rd_data),
        (q.size() > 0) ? 32'(q[0]) : 32'd0);
`ifdef UART_RX_FIFO_COUNT_EN
    chk("count", 32'(count), 32'(q.size()));
`endif
  endtask

  // One clock of stimulus; model updated at the edge.
  task automatic step(bit we, logic [DW-1:0] wd, bit re, bit clr);
    bit rdo, wacc, drop;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    ovf_clr = clr;
    @(negedge clk);
    if (re && q.size() > 0)
      chk("pop_data", 32'(rd_data), 32'(q[0]));
    rdo  = re && (q.size() > 0);
    wacc = we && ((q.size() < DP) || re);
    drop = we && (q.size() == DP) && !re;
    @(posedge clk);
    if (rdo) last_pop = q.pop_front();
    if (wacc) q.push_back(wd);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    check_state();
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DP; i++)
      step(1'b1, DW'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1, 8'hA5, 0, 0, 0, 0, 0, 8'hA5};
    tbl[1] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    tbl[2] = '{1, 8'h3C, 1, 0, 0, 0, 0, 8'h3C};
    tbl[3] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    tbl[4] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    tbl[5] = '{1, 8'h11, 0, 0, 0, 0, 0, 8'h11};
    tbl[6] = '{1, 8'h22, 0, 0, 0, 0, 0, 8'h11};
    tbl[7] = '{1, 8'h33, 1, 0, 0, 0, 0, 8'h22};
    tbl[8] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h33};
    tbl[9] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00};

    m_ovf    = 1'b0;
    last_pop = '0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single byte, simultaneous on empty, read on empty.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].clr);
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(tbl[i].e_data));
    end

    // Fill to full, drain in order.
    fill_seq();
    chk("t2_full", 32'(full), 32'd1);
    drain(DP);
    chk("t2_last", 32'(last_pop), 32'h0F);
    chk("t2_empty", 32'(empty), 32'd1);

    // Drop on full sets overflow, contents untouched.
    fill_seq();
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_full", 32'(full), 32'd1);
    drain(DP);
    chk("t3_last", 32'(last_pop), 32'h0F);
    chk("t3_empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'd0);

    // Write and read together while full.
    fill_seq();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_pop", 32'(last_pop), 32'h00);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    drain(DP);
    chk("t4_last", 32'(last_pop), 32'h55);

    // Drop and clear in the same cycle: set wins.
    fill_seq();
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("t5_ovf", 32'(overflow), 32'd1);

    // Asynchronous reset with five entries held.
    drain(DP - 5);
    chk("t6_held", 32'(empty), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_data", 32'(rd_data), 32'd0);
`ifdef UART_RX_FIFO_COUNT_EN
    chk("t6_count", 32'(count), 32'd0);
`endif
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Long stream so both pointers wrap past 2*DEPTH.
    for (int i = 0; i < 40; i++)
      step(1'b1, DW'(i * 7 + 3), q.size() >= 4, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_last", 32'(last_pop), 32'(DW'(39 * 7 + 3)));
    chk("t6_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
